// File: rtl/mem_pkg.sv
// mem_pkg
// Shared types and constants for the memory-side responder.
//   mem_state_t : boot/run phase of the responder FSM
//   VECTOR_ADDR : byte address of the CPU exception-vector word
package mem_pkg;

  typedef enum logic {
    MEM_BOOT,
    MEM_RUN
  } mem_state_t;

  localparam logic [31:0] VECTOR_ADDR = 32'd252;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Single-port word RAM with a registered, write-first read port.
// The storage itself is never reset, so its contents survive a reset.
// Only the output register is cleared.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high clear of the output register only
//   clear : synchronous clear of the output register (has priority)
//   we    : write enable for the addressed word
//   addr  : word index
//   wdata : write data; also the read-back value on a write
//   rdata : registered read data
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Clear wins over a write so loader writes during boot never reach the
  // output. A write returns its own data instead of the stale word.
  always_comb begin
    rdata_d = mem[addr];
    if (clear) begin
      rdata_d = 32'd0;
    end else if (we) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU's single memory port.
// After reset it optionally boots: it fills the RAM from a valid/ready
// loader stream and holds the CPU in reset. It then serves CPU reads and
// writes with one-cycle registered data and address-fault detection.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   Address, Wr, Datain   : CPU byte address, write strobe, write data
//   Dataout, AddrFault    : registered read data and fault flag
//   load_valid/data/last  : loader stream input
//   load_ready            : loader word accepted on valid && ready
//   cpu_hold              : keep the CPU in reset while booting
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter bit BOOT_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        AddrFault,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam int          PW          = AW + 1;
  localparam logic [31:0] BYTE_LIMIT  = 32'(4 * DEPTH_WORDS);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH_WORDS - 1);
  localparam mem_state_t  RESET_STATE = BOOT_EN ? MEM_BOOT : MEM_RUN;

  mem_state_t    state_d, state_q;
  logic [PW-1:0] ptr_d, ptr_q;
  logic          addr_fault_d, addr_fault_q;

  logic          cpu_fault;
  logic          arr_we;
  logic          arr_clear;
  logic [AW-1:0] arr_addr;
  logic [31:0]   arr_wdata;

  assign cpu_fault = (Address >= BYTE_LIMIT) || (Address[1:0] != 2'b00);

  // Boot owns the RAM port and keeps the output cleared; run hands the port
  // to the CPU, dropping faulted writes and forcing Dataout to zero.
  // load_ready is masked by reset because the reset state is BOOT.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    addr_fault_d = 1'b0;
    load_ready   = 1'b0;
    cpu_hold     = 1'b0;
    arr_we       = 1'b0;
    arr_clear    = 1'b1;
    arr_addr     = ptr_q[AW-1:0];
    arr_wdata    = load_data;
    unique case (state_q)
      MEM_BOOT: begin
        load_ready = !reset;
        cpu_hold   = 1'b1;
        if (load_valid && !reset) begin
          arr_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (load_last || (ptr_q == LAST_PTR)) begin
            state_d = MEM_RUN;
          end
        end
      end
      MEM_RUN: begin
        arr_addr     = Address[AW+1:2];
        arr_wdata    = Datain;
        arr_clear    = cpu_fault;
        arr_we       = Wr && !cpu_fault;
        addr_fault_d = cpu_fault;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      ptr_q        <= '0;
      addr_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clock(clock),
    .reset(reset),
    .clear(arr_clear),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(Dataout)
  );

  assign AddrFault = addr_fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder with DEPTH_WORDS=64 and BOOT_EN=1.
// Boots through the loader, exercises reads, write-first writes, faults,
// a full boot without load_last and a reset in the middle of a boot.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] Address;
  logic        Wr;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        AddrFault;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_hold;

  int compared_count;
  int mismatch_count;

  mem_responder #(
    .DEPTH_WORDS(64),
    .BOOT_EN    (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Address   (Address),
    .Wr        (Wr),
    .Datain    (Datain),
    .Dataout   (Dataout),
    .AddrFault (AddrFault),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .cpu_hold  (cpu_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one cycle of inputs, lets the rising edge take them, and returns
  // 1 time unit after the edge so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [31:0] din, input logic lv,
                               input logic [31:0] ld, input logic ll);
    Address    = addr;
    Wr         = wr;
    Datain     = din;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    compared_count = 0;
    mismatch_count = 0;
    reset      = 1'b1;
    Address    = 32'd0;
    Wr         = 1'b0;
    Datain     = 32'd0;
    load_valid = 1'b0;
    load_data  = 32'd0;
    load_last  = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_dataout", Dataout, 32'd0);
    checkOutput("rst_fault", {31'd0, AddrFault}, 32'd0);
    checkOutput("rst_ready", {31'd0, load_ready}, 32'd0);
    checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("boot_ready", {31'd0, load_ready}, 32'd1);

    // Boot three words; CPU writes during boot must be ignored
    applyStimulus(32'd0, 1'b1, 32'hBADBAD00, 1'b1, 32'h11111111, 1'b0);
    checkOutput("boot_dout_zero", Dataout, 32'd0);
    checkOutput("boot_hold1", {31'd0, cpu_hold}, 32'd1);
    applyStimulus(32'd0, 1'b1, 32'hBADBAD00, 1'b1, 32'h22222222, 1'b0);
    checkOutput("boot_hold2", {31'd0, cpu_hold}, 32'd1);
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b1, 32'h33333333, 1'b1);
    checkOutput("boot_hold_fall", {31'd0, cpu_hold}, 32'd0);
    checkOutput("boot_ready_fall", {31'd0, load_ready}, 32'd0);
    checkOutput("boot_ptr", 32'(dut.ptr_q), 32'd3);

    // Reads in run mode
    applyStimulus(32'd4, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd4", Dataout, 32'h22222222);
    checkOutput("rd4_fault", {31'd0, AddrFault}, 32'd0);
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd0_cpu_wr_ignored", Dataout, 32'h11111111);

    // Write-first and read-back
    applyStimulus(32'd8, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    checkOutput("wr8_first", Dataout, 32'hDEADBEEF);
    applyStimulus(32'd8, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd8", Dataout, 32'hDEADBEEF);

    // Faults
    applyStimulus(32'd256, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd256_fault", {31'd0, AddrFault}, 32'd1);
    checkOutput("rd256_dout", Dataout, 32'd0);
    applyStimulus(32'd6, 1'b1, 32'h55555555, 1'b0, 32'd0, 1'b0);
    checkOutput("wr6_fault", {31'd0, AddrFault}, 32'd1);
    checkOutput("wr6_dout", Dataout, 32'd0);
    applyStimulus(32'd4, 1'b0, 32'd0, 1'b1, 32'h99999999, 1'b1);
    checkOutput("rd4_after_fault", Dataout, 32'h22222222);
    checkOutput("rd4_fault_clr", {31'd0, AddrFault}, 32'd0);
    checkOutput("run_ignores_loader", {31'd0, load_ready}, 32'd0);
    applyStimulus(32'd4, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd4_hold", Dataout, 32'h22222222);

    // Asynchronous reset clears outputs without a clock edge
    applyStimulus(32'd256, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(32'd8, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("pre_rst_rd8", Dataout, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_dout", Dataout, 32'd0);
    checkOutput("async_rst_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("async_rst_ready", {31'd0, load_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Full boot of 64 words without load_last
    for (int i = 0; i < 64; i++) begin
      applyStimulus(32'd0, 1'b0, 32'd0, 1'b1, 32'(i), 1'b0);
      if (i == 62) checkOutput("full_hold_62", {31'd0, cpu_hold}, 32'd1);
      if (i == 63) checkOutput("full_hold_63", {31'd0, cpu_hold}, 32'd0);
    end
    applyStimulus(VECTOR_ADDR, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd_vector", Dataout, 32'h0000003F);
    applyStimulus(32'd8, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd8_reloaded", Dataout, 32'h00000002);

    // Reset in the middle of a boot
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b1, 32'hCCCC0000, 1'b0);
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b1, 32'hCCCC0001, 1'b0);
    checkOutput("mid_ptr2", 32'(dut.ptr_q), 32'd2);
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("mid_ptr_clr", 32'(dut.ptr_q), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b1, 32'hAAAAAAAA, 1'b1);
    checkOutput("mid_hold_fall", {31'd0, cpu_hold}, 32'd0);
    applyStimulus(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("mid_rd0", Dataout, 32'hAAAAAAAA);
    applyStimulus(32'd4, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("mid_rd4_kept", Dataout, 32'hCCCC0001);
    applyStimulus(32'd12, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("mid_rd12_kept", Dataout, 32'h00000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $finish;
  end

endmodule
